// File: rtl/ex_mem_bundle_queue_pkg.sv
// Shared pipeline types for the EX->MEM bundle queue: lane defaults,
// the bundle record and the redirect kill rule.
package ex_mem_bundle_queue_pkg;

    localparam int ISSUE_WIDTH = 2;
    localparam int PAYLOAD_W   = 128;

    typedef struct packed {
        logic [ISSUE_WIDTH-1:0]                valid;
        logic [ISSUE_WIDTH-1:0][PAYLOAD_W-1:0] payload;
    } ex_mem_bundle_t;

    // Whether a lane survives a redirect taken by lane 'oldest' (lane 0 is oldest).
    function automatic logic redirect_keeps_lane(input int lane, input int oldest, input logic keep);
        return (lane < oldest) || ((lane == oldest) && keep);
    endfunction

endpackage

// File: rtl/ex_mem_bundle_queue_if.sv
// Execute-side and mem-side handshake of the EX->MEM bundle queue.
interface ex_mem_bundle_queue_if #(
    parameter int ISSUE_WIDTH = 2,
    parameter int PAYLOAD_W   = 128,
    parameter int DEPTH       = 2
);
    localparam int RL_W  = $clog2(ISSUE_WIDTH) + 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                                  flush;
    logic [ISSUE_WIDTH-1:0]                in_valid;
    logic [ISSUE_WIDTH-1:0]                in_redirect;
    logic [ISSUE_WIDTH-1:0][PAYLOAD_W-1:0] in_payload;
    logic                                  in_ready;
    logic                                  branch_flush;
    logic [RL_W-1:0]                       redirect_lane;
    logic [ISSUE_WIDTH-1:0]                out_valid;
    logic [ISSUE_WIDTH-1:0][PAYLOAD_W-1:0] out_payload;
    logic                                  out_ready;
    logic [CNT_W-1:0]                      count;

    modport master (
        output flush, in_valid, in_redirect, in_payload, out_ready,
        input  in_ready, branch_flush, redirect_lane, out_valid, out_payload, count
    );

    modport slave (
        input  flush, in_valid, in_redirect, in_payload, out_ready,
        output in_ready, branch_flush, redirect_lane, out_valid, out_payload, count
    );

endinterface

// File: rtl/ex_mem_bundle_queue_fifo_ctrl.sv
// Read/write pointers and occupancy for the bundle queue; pointers wrap at
// DEPTH-1 so any depth works.
module bundle_fifo_ctrl #(
    parameter int DEPTH = 2,
    parameter int PTR_W = 1,
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             enq,
    input  logic             deq,
    output logic [PTR_W-1:0] wr_ptr,
    output logic [PTR_W-1:0] rd_ptr,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);
    import ex_mem_bundle_queue_pkg::*;

    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) wr_ptr <= bump(wr_ptr);
            if (deq) rd_ptr <= bump(rd_ptr);
            case ({enq, deq})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/ex_mem_bundle_queue.sv
// EX->MEM bundle queue: applies in-order redirect kill across lanes, buffers
// DEPTH bundles behind a valid/ready handshake and reports accepted redirects.
module ex_mem_bundle_queue #(
    parameter int ISSUE_WIDTH        = ex_mem_bundle_queue_pkg::ISSUE_WIDTH,
    parameter int PAYLOAD_W          = ex_mem_bundle_queue_pkg::PAYLOAD_W,
    parameter int DEPTH              = 2,
    parameter int KEEP_REDIRECT_LANE = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    ex_mem_bundle_queue_if.slave  q
);
    import ex_mem_bundle_queue_pkg::*;

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int RL_W  = $clog2(ISSUE_WIDTH) + 1;

    typedef struct packed {
        logic [ISSUE_WIDTH-1:0]                valid;
        logic [ISSUE_WIDTH-1:0][PAYLOAD_W-1:0] payload;
    } bundle_t;

    logic [ISSUE_WIDTH-1:0] hit;
    logic [ISSUE_WIDTH-1:0] masked_valid;
    logic [RL_W-1:0]        oldest_lane;
    int                     oldest_idx;
    logic                   accept, enq, deq, full, empty;
    logic [PTR_W-1:0]       wr_ptr, rd_ptr;
    logic [CNT_W-1:0]       count;
    bundle_t                entry_q [DEPTH];
    bundle_t                wr_bundle;
    bundle_t                head;

    assign hit = q.in_valid & q.in_redirect;

    always_comb begin
        oldest_idx = ISSUE_WIDTH;
        for (int i = ISSUE_WIDTH - 1; i >= 0; i--) begin
            if (hit[i]) oldest_idx = i;
        end
        oldest_lane = (|hit) ? RL_W'(oldest_idx) : '0;
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            masked_valid[i] = q.in_valid[i] &
                              (~|hit | redirect_keeps_lane(i, oldest_idx, KEEP_REDIRECT_LANE != 0));
        end
        wr_bundle.valid = masked_valid;
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            wr_bundle.payload[i] = masked_valid[i] ? q.in_payload[i] : '0;
        end
    end

    // rst gates accept so a reset cycle can never signal a redirect to ctrl.
    assign accept = ~full & (|q.in_valid) & ~q.flush & rst;
    assign enq    = accept & (|masked_valid);
    assign deq    = ~empty & q.out_ready & ~q.flush;

    bundle_fifo_ctrl #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W),
        .CNT_W (CNT_W)
    ) u_ctrl (
        .clk    (clk),
        .rst    (rst),
        .flush  (q.flush),
        .enq    (enq),
        .deq    (deq),
        .wr_ptr (wr_ptr),
        .rd_ptr (rd_ptr),
        .count  (count),
        .full   (full),
        .empty  (empty)
    );

    always_ff @(posedge clk) begin
        if (!rst || q.flush) begin
            for (int i = 0; i < DEPTH; i++) entry_q[i].valid <= '0;
        end else if (enq) begin
            entry_q[wr_ptr] <= wr_bundle;
        end
    end

    assign head            = entry_q[rd_ptr];
    assign q.out_valid     = empty ? '0 : head.valid;
    assign q.out_payload   = empty ? '0 : head.payload;
    assign q.in_ready      = ~full;
    assign q.branch_flush  = accept & (|hit);
    assign q.redirect_lane = q.branch_flush ? oldest_lane : '0;
    assign q.count         = count;

endmodule

// File: tb/tb_ex_mem_bundle_queue.sv
// Bench: three queue configurations driven in lockstep and compared against
// a queue-of-bundles reference model.
module tb_ex_mem_bundle_queue;

    localparam int W    = 2;
    localparam int PW   = 128;
    localparam int NDUT = 3;

    typedef struct {
        logic [W-1:0]         v;
        logic [W-1:0][PW-1:0] p;
    } mb_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 flush;
    logic                 out_ready;
    logic [W-1:0]         in_valid;
    logic [W-1:0]         in_redirect;
    logic [W-1:0][PW-1:0] in_payload;

    logic [W-1:0]         o_valid   [NDUT];
    logic [W-1:0][PW-1:0] o_payload [NDUT];
    logic                 o_in_ready[NDUT];
    logic                 o_bf      [NDUT];
    logic [1:0]           o_rl      [NDUT];
    logic [1:0]           o_count   [NDUT];

    always #5 clk = ~clk;

    // dut0: DEPTH=2 KEEP=1, dut1: DEPTH=2 KEEP=0, dut2: DEPTH=3 KEEP=1
    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int DEP  = (g == 2) ? 3 : 2;
        localparam int KEEP = (g == 1) ? 0 : 1;
        ex_mem_bundle_queue_if #(.ISSUE_WIDTH(W), .PAYLOAD_W(PW), .DEPTH(DEP)) bus ();
        assign bus.flush       = flush;
        assign bus.in_valid    = in_valid;
        assign bus.in_redirect = in_redirect;
        assign bus.in_payload  = in_payload;
        assign bus.out_ready   = out_ready;
        ex_mem_bundle_queue #(
            .ISSUE_WIDTH        (W),
            .PAYLOAD_W          (PW),
            .DEPTH              (DEP),
            .KEEP_REDIRECT_LANE (KEEP)
        ) dut (
            .clk (clk),
            .rst (rst),
            .q   (bus.slave)
        );
        assign o_valid[g]    = bus.out_valid;
        assign o_payload[g]  = bus.out_payload;
        assign o_in_ready[g] = bus.in_ready;
        assign o_bf[g]       = bus.branch_flush;
        assign o_rl[g]       = bus.redirect_lane;
        assign o_count[g]    = bus.count;
    end

    mb_t mq [NDUT][$];
    int  checks   = 0;
    int  failures = 0;

    function automatic int depth_of(input int g);
        return (g == 2) ? 3 : 2;
    endfunction

    function automatic bit keep_of(input int g);
        return g != 1;
    endfunction

    task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge: checks registered state, drives one cycle, checks
    // the combinational redirect outputs, then advances the model.
    task automatic step(input logic rs, input logic fl, input logic [W-1:0] v,
                        input logic [W-1:0] rd, input logic ordy);
        for (int g = 0; g < NDUT; g++) begin
            int n;
            logic [255:0] ep;
            logic [W-1:0] ev;
            n  = mq[g].size();
            ep = '0;
            ev = '0;
            if (n > 0) begin
                ep = mq[g][0].p;
                ev = mq[g][0].v;
            end
            check_eq($sformatf("d%0d_count", g), o_count[g], n);
            check_eq($sformatf("d%0d_in_ready", g), o_in_ready[g], n != depth_of(g));
            check_eq($sformatf("d%0d_out_valid", g), o_valid[g], ev);
            check_eq($sformatf("d%0d_out_payload", g), o_payload[g], ep);
        end
        rst         = rs;
        flush       = fl;
        in_valid    = v;
        in_redirect = rd;
        out_ready   = ordy;
        for (int l = 0; l < W; l++) in_payload[l] = {$urandom, $urandom, $urandom, $urandom};
        #1;
        for (int g = 0; g < NDUT; g++) begin
            int  n, rr;
            bit  hit, acc;
            mb_t b;
            n   = mq[g].size();
            hit = 0;
            rr  = 0;
            for (int l = 0; l < W; l++) begin
                if (!hit && v[l] && rd[l]) begin
                    hit = 1;
                    rr  = l;
                end
            end
            for (int l = 0; l < W; l++) begin
                b.v[l] = v[l] && (!hit || l < rr || (l == rr && keep_of(g)));
                b.p[l] = b.v[l] ? in_payload[l] : '0;
            end
            acc = rs && !fl && (n != depth_of(g)) && (v != 0);
            check_eq($sformatf("d%0d_branch_flush", g), o_bf[g], acc && hit);
            check_eq($sformatf("d%0d_redirect_lane", g), o_rl[g], (acc && hit) ? rr : 0);
            if (!rs || fl) begin
                mq[g].delete();
            end else begin
                if (n > 0 && ordy) void'(mq[g].pop_front());
                if (acc && b.v != 0) mq[g].push_back(b);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst         = 1'b0;
        flush       = 1'b0;
        out_ready   = 1'b0;
        in_valid    = '0;
        in_redirect = '0;
        in_payload  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // fill with A (11) and B (01) while mem stalls
        step(1, 0, 2'b11, 2'b00, 0);
        step(1, 0, 2'b01, 2'b00, 0);
        check_eq("plan_full_count", o_count[0], 2);
        check_eq("plan_full_in_ready", o_in_ready[0], 0);
        check_eq("plan_full_head", o_valid[0], 2'b11);
        // full stall with a redirect offered, then drain one
        step(1, 0, 2'b11, 2'b01, 0);
        step(1, 0, 2'b00, 2'b00, 1);
        check_eq("plan_after_deq_count", o_count[0], 1);
        check_eq("plan_after_deq_head", o_valid[0], 2'b01);
        repeat (3) step(1, 0, 2'b00, 2'b00, 1);

        // redirect kill on lane 0
        step(1, 0, 2'b11, 2'b01, 0);
        check_eq("plan_kill_keep1", o_valid[0], 2'b01);
        check_eq("plan_kill_keep0_count", o_count[1], 0);
        step(1, 0, 2'b11, 2'b10, 0);
        step(1, 0, 2'b11, 2'b11, 1);

        // flush mid-stream with input and out_ready active
        step(1, 1, 2'b11, 2'b01, 1);
        check_eq("plan_flush_count", o_count[2], 0);
        check_eq("plan_flush_payload", o_payload[2], '0);

        // simultaneous enqueue/dequeue at count 1
        step(1, 0, 2'b01, 2'b00, 0);
        step(1, 0, 2'b10, 2'b00, 1);
        check_eq("plan_enq_deq_count", o_count[0], 1);
        check_eq("plan_enq_deq_head", o_valid[0], 2'b10);

        // wrap stream, out_ready toggling 1,0,1,...
        for (int k = 0; k < 10; k++) begin
            logic [W-1:0] v;
            v = W'($urandom_range(1, 3));
            step(1, 0, v, 2'b00, (k % 2) == 0);
        end
        repeat (4) step(1, 0, 2'b00, 2'b00, 1);

        // randomized traffic, including occasional flush and mid-run reset
        for (int k = 0; k < 700; k++) begin
            logic rs, fl, ordy;
            logic [W-1:0] v, rd;
            rs   = ($urandom_range(63) != 0);
            fl   = ($urandom_range(15) == 0);
            v    = W'($urandom);
            rd   = ($urandom_range(2) == 0) ? W'($urandom) : '0;
            ordy = ($urandom_range(2) != 0);
            step(rs, fl, v, rd, ordy);
        end
        step(1, 0, 2'b00, 2'b00, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
